// File: rtl/pio_poll_master.sv
// Avalon-MM initiator for an input PIO slave: programs the irq mask, reads the data register on irq edges or a poll timer.
// Optional build macro PIO_POLL_CHANGE_ONLY_EN: sample_valid strobes only when the captured value changes.
module pio_poll_master #(
    parameter int                    DATA_WIDTH  = 18,
    parameter int                    POLL_PERIOD = 50000,
    parameter logic [DATA_WIDTH-1:0] MASK_INIT   = 18'h3FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [1:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  irq,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] mask_value,
    input  logic                  mask_load,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    output logic                  busy
);

    localparam int                  TIMER_W      = $clog2(POLL_PERIOD);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_PERIOD - 1);
    localparam logic [1:0]         ADDR_DATA    = 2'd0;
    localparam logic [1:0]         ADDR_MASK    = 2'd2;

    typedef enum logic [2:0] {
        S_INIT,
        S_WR_MASK,
        S_IDLE,
        S_RD_ADDR,
        S_RD_CAPTURE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              addr_q, addr_d;
    logic                    cs_q, cs_d;
    logic                    write_n_q, write_n_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   sample_data_q, sample_data_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    busy_q, busy_d;
    logic                    pend_rd_q, pend_rd_d;
    logic                    pend_mask_q, pend_mask_d;
    logic [DATA_WIDTH-1:0]   mask_reg_q, mask_reg_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic                    irq_q;
`ifdef PIO_POLL_CHANGE_ONLY_EN
    logic                    first_q, first_d;
`endif

    logic                    irq_rise;
    logic                    timer_zero;
    logic                    trig;
    logic [DATA_WIDTH-1:0]   rd_value;
    logic                    unused_rd_hi;

    assign irq_rise     = irq & ~irq_q;
    assign timer_zero   = (timer_q == '0);
    assign trig         = enable & (irq_rise | timer_zero);
    assign rd_value     = avm_readdata[DATA_WIDTH-1:0];
    assign unused_rd_hi = ^avm_readdata[31:DATA_WIDTH];

    always_comb begin
        state_d        = state_q;
        cs_d           = 1'b0;
        write_n_d      = 1'b1;
        addr_d         = '0;
        wdata_d        = '0;
        sample_data_d  = sample_data_q;
        sample_valid_d = 1'b0;
        pend_rd_d      = pend_rd_q | trig;
        pend_mask_d    = pend_mask_q | mask_load;
        mask_reg_d     = mask_load ? mask_value : mask_reg_q;
`ifdef PIO_POLL_CHANGE_ONLY_EN
        first_d        = first_q;
`endif

        if (!enable)
            timer_d = timer_q;
        else if (timer_zero)
            timer_d = TIMER_RELOAD;
        else
            timer_d = timer_q - TIMER_W'(1);

        case (state_q)
            S_INIT: begin
                // A mask_load arriving here stays pending and is written after the initial mask.
                state_d   = S_WR_MASK;
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = ADDR_MASK;
                wdata_d   = 32'(MASK_INIT);
                if (!mask_load)
                    mask_reg_d = MASK_INIT;
            end
            S_WR_MASK: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (pend_mask_q || mask_load) begin
                    state_d     = S_WR_MASK;
                    cs_d        = 1'b1;
                    write_n_d   = 1'b0;
                    addr_d      = ADDR_MASK;
                    wdata_d     = 32'(mask_reg_d);
                    pend_mask_d = 1'b0;
                end else if (pend_rd_q || trig) begin
                    state_d   = S_RD_ADDR;
                    cs_d      = 1'b1;
                    addr_d    = ADDR_DATA;
                    pend_rd_d = 1'b0;
                    timer_d   = TIMER_RELOAD;
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                // Slave has latency 1, so readdata is valid during this cycle.
                state_d       = S_IDLE;
                sample_data_d = rd_value;
`ifdef PIO_POLL_CHANGE_ONLY_EN
                sample_valid_d = first_q | (rd_value != sample_data_q);
                first_d        = 1'b0;
`else
                sample_valid_d = 1'b1;
`endif
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_INIT;
            cs_q           <= 1'b0;
            write_n_q      <= 1'b1;
            addr_q         <= '0;
            wdata_q        <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b1;
            pend_rd_q      <= 1'b0;
            pend_mask_q    <= 1'b0;
            mask_reg_q     <= MASK_INIT;
            timer_q        <= TIMER_RELOAD;
            irq_q          <= 1'b0;
`ifdef PIO_POLL_CHANGE_ONLY_EN
            first_q        <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            cs_q           <= cs_d;
            write_n_q      <= write_n_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            pend_rd_q      <= pend_rd_d;
            pend_mask_q    <= pend_mask_d;
            mask_reg_q     <= mask_reg_d;
            timer_q        <= timer_d;
            irq_q          <= irq;
`ifdef PIO_POLL_CHANGE_ONLY_EN
            first_q        <= first_d;
`endif
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = wdata_q;
    assign sample_data    = sample_data_q;
    assign sample_valid   = sample_valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master with POLL_PERIOD=8 and a latency-1 PIO slave model.
`timescale 1ns/1ps
module tb_pio_poll_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        irq = 1'b0;
    logic        enable = 1'b0;
    logic [17:0] mask_value = '0;
    logic        mask_load = 1'b0;
    logic [17:0] sample_data;
    logic        sample_valid;
    logic        busy;
    logic [17:0] slave_data = '0;
    int          checks = 0;
    int          failures = 0;

    pio_poll_master #(
        .DATA_WIDTH (18),
        .POLL_PERIOD(8),
        .MASK_INIT  (18'h3FFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .irq           (irq),
        .enable        (enable),
        .mask_value    (mask_value),
        .mask_load     (mask_load),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Latency-1 slave: data register returned the cycle after address 0 is selected.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n && avm_address == 2'd0)
            avm_readdata <= {14'b0, slave_data};
    end

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; mask_load = 1'b0; irq = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; mask_load = 1'b0; irq = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (avm_chipselect !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", avm_chipselect); end
        checks++; if (avm_write_n !== 1'b1) begin failures++; $display("FAIL reset_write_n got=%b exp=1", avm_write_n); end
        checks++; if (avm_writedata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", avm_writedata); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (sample_valid !== 1'b0 || sample_data !== 18'h0) begin failures++; $display("FAIL reset_sample got=%b/%h exp=0/0", sample_valid, sample_data); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 2'd2) begin
            failures++; $display("FAIL init_wr_ctrl got cs=%b wn=%b addr=%0d exp cs=1 wn=0 addr=2", avm_chipselect, avm_write_n, avm_address); end
        checks++; if (avm_writedata !== 32'h0003FFFF) begin failures++; $display("FAIL init_wr_data got=%h exp=0003ffff", avm_writedata); end
        @(negedge clk);
        checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_writedata !== 32'h0) begin
            failures++; $display("FAIL init_idle_bus got cs=%b wn=%b wd=%h exp 0/1/0", avm_chipselect, avm_write_n, avm_writedata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL init_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_poll();
        logic rd_now, exp_rd, exp_v;
        do_reset();
        slave_data = 18'h12345;
        enable = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            rd_now = avm_chipselect & avm_write_n & (avm_address == 2'd0);
            exp_rd = (i % 8 == 0);
            exp_v  = (i >= 10) && ((i - 10) % 8 == 0);
            checks++; if (rd_now !== exp_rd) begin failures++; $display("FAIL poll_read cyc=%0d got=%b exp=%b", i, rd_now, exp_rd); end
            checks++; if (sample_valid !== exp_v) begin failures++; $display("FAIL poll_valid cyc=%0d got=%b exp=%b", i, sample_valid, exp_v); end
            if (exp_v) begin
                checks++; if (sample_data !== 18'h12345) begin failures++; $display("FAIL poll_data cyc=%0d got=%h exp=12345", i, sample_data); end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_irq();
        logic rd_now, exp_rd, exp_v;
        do_reset();
        slave_data = 18'h00001;
        enable = 1'b1;
        irq = 1'b1;
        // Irq held high: only the initial edge plus the regular poll reads may appear.
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            rd_now = avm_chipselect & avm_write_n & (avm_address == 2'd0);
            exp_rd = (i % 8 == 1);
            exp_v  = (i >= 3) && ((i - 3) % 8 == 0);
            checks++; if (rd_now !== exp_rd) begin failures++; $display("FAIL irq_read cyc=%0d got=%b exp=%b", i, rd_now, exp_rd); end
            checks++; if (sample_valid !== exp_v) begin failures++; $display("FAIL irq_valid cyc=%0d got=%b exp=%b", i, sample_valid, exp_v); end
            if (i == 3) begin
                checks++; if (sample_data !== 18'h00001) begin failures++; $display("FAIL irq_data got=%h exp=00001", sample_data); end
            end
        end
        irq = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_mask_and_poll();
        do_reset();
        slave_data = 18'h2AAAA;
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i <= 7 || i == 9 || i == 11) begin
                checks++; if (avm_chipselect !== 1'b0) begin failures++; $display("FAIL mp_idle cyc=%0d got cs=%b exp=0", i, avm_chipselect); end
            end else if (i == 8) begin
                checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 2'd2 || avm_writedata !== 32'h000000F0) begin
                    failures++; $display("FAIL mp_wr got cs=%b wn=%b addr=%0d wd=%h exp 1/0/2/000000f0", avm_chipselect, avm_write_n, avm_address, avm_writedata); end
            end else if (i == 10) begin
                checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b1 || avm_address !== 2'd0) begin
                    failures++; $display("FAIL mp_rd got cs=%b wn=%b addr=%0d exp 1/1/0", avm_chipselect, avm_write_n, avm_address); end
            end else begin
                checks++; if (sample_valid !== 1'b1 || sample_data !== 18'h2AAAA) begin
                    failures++; $display("FAIL mp_sample got v=%b d=%h exp 1/2aaaa", sample_valid, sample_data); end
            end
            mask_load  = (i == 7);
            mask_value = 18'h000F0;
        end
        enable = 1'b0;
    endtask

    task automatic test_mask_overwrite();
        reset = 1'b1; enable = 1'b0; mask_load = 1'b0; irq = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; mask_load = 1'b1; mask_value = 18'h00022;
        @(negedge clk);
        checks++; if (avm_chipselect !== 1'b1 || avm_writedata !== 32'h0003FFFF) begin
            failures++; $display("FAIL ow_first got cs=%b wd=%h exp 1/0003ffff", avm_chipselect, avm_writedata); end
        mask_value = 18'h00033;
        @(negedge clk);
        checks++; if (avm_chipselect !== 1'b0) begin failures++; $display("FAIL ow_gap got cs=%b exp=0", avm_chipselect); end
        mask_load = 1'b0;
        @(negedge clk);
        checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_writedata !== 32'h00000033) begin
            failures++; $display("FAIL ow_last got cs=%b wn=%b wd=%h exp 1/0/00000033", avm_chipselect, avm_write_n, avm_writedata); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (avm_chipselect !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL ow_after got cs=%b busy=%b exp 0/0", avm_chipselect, busy); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        slave_data = 18'h1ABCD;
        enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 10) begin
                checks++; if (sample_valid !== 1'b1 || sample_data !== 18'h1ABCD) begin
                    failures++; $display("FAIL rm_first got v=%b d=%h exp 1/1abcd", sample_valid, sample_data); end
            end
        end
        checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b1 || avm_address !== 2'd0) begin
            failures++; $display("FAIL rm_rdaddr got cs=%b wn=%b addr=%0d exp 1/1/0", avm_chipselect, avm_write_n, avm_address); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL rm_bus got cs=%b wn=%b busy=%b exp 0/1/1", avm_chipselect, avm_write_n, busy); end
        checks++; if (sample_valid !== 1'b0 || sample_data !== 18'h0) begin
            failures++; $display("FAIL rm_sample got v=%b d=%h exp 0/0", sample_valid, sample_data); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 2'd2 || avm_writedata !== 32'h0003FFFF) begin
            failures++; $display("FAIL rm_rewrite got cs=%b wn=%b addr=%0d wd=%h exp 1/0/2/0003ffff", avm_chipselect, avm_write_n, avm_address, avm_writedata); end
        enable = 1'b0;
    endtask

    task automatic test_change_only();
        logic [17:0] v [3];
        int n;
        v[0] = '0; v[1] = '0; v[2] = '0;
        n = 0;
        do_reset();
        slave_data = 18'h5;
        enable = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            if (i == 20) slave_data = 18'h7;
            if (sample_valid === 1'b1) begin
                if (n < 3) v[n] = sample_data;
                n++;
            end
        end
        enable = 1'b0;
`ifdef PIO_POLL_CHANGE_ONLY_EN
        checks++; if (n !== 2) begin failures++; $display("FAIL co_count got=%0d exp=2", n); end
        checks++; if (v[0] !== 18'h5 || v[1] !== 18'h7) begin failures++; $display("FAIL co_values got=%h,%h exp=5,7", v[0], v[1]); end
`else
        checks++; if (n !== 3) begin failures++; $display("FAIL co_count got=%0d exp=3", n); end
        checks++; if (v[0] !== 18'h5 || v[1] !== 18'h5 || v[2] !== 18'h7) begin
            failures++; $display("FAIL co_values got=%h,%h,%h exp=5,5,7", v[0], v[1], v[2]); end
`endif
        checks++; if (sample_data !== 18'h7) begin failures++; $display("FAIL co_last got=%h exp=7", sample_data); end
    endtask

    initial begin
        test_reset();
        test_poll();
        test_irq();
        test_mask_and_poll();
        test_mask_overwrite();
        test_reset_mid();
        test_change_only();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
